// File: rtl/circle_pkg.sv
// Shared types and widths for the midpoint circle point generator.
package circle_pkg;

    localparam int unsigned COORD_W = 8;
    localparam int unsigned SCRD_W  = COORD_W + 2;
    localparam int unsigned D_W     = COORD_W + 4;
    localparam int unsigned OCT_W   = 3;

    typedef logic [COORD_W-1:0]       coord_t;
    typedef logic signed [SCRD_W-1:0] scoord_t;
    typedef logic signed [D_W-1:0]    dval_t;
    typedef logic [OCT_W-1:0]         oct_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        EMIT = 3'd2,
        STEP = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/circle_octant_map.sv
// Maps (x, y, octant) around the centre to a pixel, with clip and duplicate-slot flags.
module circle_octant_map
    import circle_pkg::*;
(
    input  scoord_t                x,
    input  scoord_t                y,
    input  oct_t                   oct,
    input  logic [COORD_W-1:0]     cx,
    input  logic [COORD_W-1:0]     cy,
    input  logic                   r_zero,
    output logic [COORD_W-1:0]     px,
    output logic [COORD_W-1:0]     py,
    output logic                   in_range,
    output logic                   slot_en
);

    scoord_t cxs;
    scoord_t cys;
    scoord_t px_s;
    scoord_t py_s;

    // Octant coordinate selection in widened signed arithmetic
    always_comb begin
        cxs  = scoord_t'(cx);
        cys  = scoord_t'(cy);
        px_s = cxs;
        py_s = cys;
        case (oct)
            3'd0: begin px_s = cxs + x; py_s = cys + y; end
            3'd1: begin px_s = cxs + y; py_s = cys + x; end
            3'd2: begin px_s = cxs - y; py_s = cys + x; end
            3'd3: begin px_s = cxs - x; py_s = cys + y; end
            3'd4: begin px_s = cxs - x; py_s = cys - y; end
            3'd5: begin px_s = cxs - y; py_s = cys - x; end
            3'd6: begin px_s = cxs + y; py_s = cys - x; end
            default: begin px_s = cxs + x; py_s = cys - y; end
        endcase
    end

    // Suppress slots that would repeat a pixel on the axes or the diagonal
    always_comb begin
        slot_en = 1'b1;
        if (r_zero)
            slot_en = (oct == 3'd0);
        else if (y == '0)
            slot_en = (oct == 3'd0) || (oct == 3'd1) || (oct == 3'd3) || (oct == 3'd5);
        else if (x == y)
            slot_en = (oct == 3'd0) || (oct == 3'd2) || (oct == 3'd4) || (oct == 3'd6);
    end

    assign in_range = (px_s[SCRD_W-1:COORD_W] == 2'b00) && (py_s[SCRD_W-1:COORD_W] == 2'b00);
    assign px       = px_s[COORD_W-1:0];
    assign py       = py_s[COORD_W-1:0];

endmodule

// File: rtl/circle_point_gen.sv
// Midpoint circle rasteriser: streams circle pixels over a valid/ready interface.
module circle_point_gen
    import circle_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    input  logic [COORD_W-1:0] radius,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               busy,
    output logic               done
);

    state_t  state_q, state_d;
    coord_t  cx_q, cx_d, cy_q, cy_d, r_q, r_d;
    scoord_t x_q, x_d, y_q, y_d;
    dval_t   d_q, d_d;
    oct_t    oct_q, oct_d;
    logic    out_valid_q, out_valid_d;
    coord_t  px_q, px_d, py_q, py_d;
    logic    busy_q, busy_d, done_q, done_d;

    coord_t  map_px, map_py;
    logic    map_in_range, map_slot_en;
    logic    out_free;
    scoord_t y_inc, x_dec, x_step;
    dval_t   d_step;
    logic    step_exit;

    circle_octant_map u_map (
        .x        (x_q),
        .y        (y_q),
        .oct      (oct_q),
        .cx       (cx_q),
        .cy       (cy_q),
        .r_zero   (r_q == '0),
        .px       (map_px),
        .py       (map_py),
        .in_range (map_in_range),
        .slot_en  (map_slot_en)
    );

    // Next midpoint step: advance y, maybe retreat x, update decision variable
    always_comb begin
        y_inc = y_q + scoord_t'(1);
        x_dec = x_q - scoord_t'(1);
        if (d_q < 0) begin
            x_step = x_q;
            d_step = d_q + (dval_t'(y_inc) <<< 1) + dval_t'(1);
        end else begin
            x_step = x_dec;
            d_step = d_q + ((dval_t'(y_inc) - dval_t'(x_dec)) <<< 1) + dval_t'(1);
        end
        step_exit = (x_step < y_inc);
    end

    // FSM next state, datapath and registered output next values
    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        r_d         = r_q;
        x_d         = x_q;
        y_d         = y_q;
        d_d         = d_q;
        oct_d       = oct_q;
        out_valid_d = out_valid_q;
        px_d        = px_q;
        py_d        = py_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_free    = !out_valid_q || out_ready;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cx_d    = cx;
                    cy_d    = cy;
                    r_d     = radius;
                    busy_d  = 1'b1;
                    state_d = INIT;
                end
            end
            INIT: begin
                x_d     = scoord_t'(r_q);
                y_d     = '0;
                d_d     = dval_t'(1) - dval_t'(r_q);
                oct_d   = '0;
                state_d = EMIT;
            end
            EMIT: begin
                if (out_free) begin
                    if (map_slot_en && map_in_range) begin
                        out_valid_d = 1'b1;
                        px_d        = map_px;
                        py_d        = map_py;
                    end
                    if (oct_q == 3'd7)
                        state_d = STEP;
                    else
                        oct_d = oct_q + 3'd1;
                end
            end
            STEP: begin
                // The final point must be accepted before done can be raised
                if (step_exit) begin
                    if (out_free) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end else begin
                    x_d     = x_step;
                    y_d     = y_inc;
                    d_d     = d_step;
                    oct_d   = '0;
                    state_d = EMIT;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cx_q        <= '0;
            cy_q        <= '0;
            r_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            d_q         <= '0;
            oct_q       <= '0;
            out_valid_q <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            r_q         <= r_d;
            x_q         <= x_d;
            y_q         <= y_d;
            d_q         <= d_d;
            oct_q       <= oct_d;
            out_valid_q <= out_valid_d;
            px_q        <= px_d;
            py_q        <= py_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign px        = px_q;
    assign py        = py_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_circle_point_gen.sv
// Directed bench for circle_point_gen.
module tb_circle_point_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cx = '0, cy = '0, radius = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] px, py;
    logic       busy, done;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0] got_x [64];
    logic [7:0] got_y [64];
    int         got_n;
    int         got_done;
    bit         got_stable;
    bit         got_timeout;

    int exp2_x [12] = '{102, 100,  98, 100, 102, 101,  99,  98,  98,  99, 101, 102};
    int exp2_y [12] = '{100, 102, 100,  98, 101, 102, 102, 101,  99,  98,  98,  99};

    circle_point_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cx        (cx),
        .cy        (cy),
        .radius    (radius),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .px        (px),
        .py        (py),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Drive a one-cycle start pulse; returns #1 after the sampling edge
    task automatic kick(input int x0, input int y0, input int r);
        cx = 8'(x0); cy = 8'(y0); radius = 8'(r); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Record accepted points until busy falls; optionally re-pulse start mid-run
    task automatic collect(input int pct, input int restart_at);
        bit         hold = 1'b0;
        logic [7:0] hx = '0, hy = '0;
        bit         rdy;
        got_n = 0; got_done = 0; got_stable = 1'b1; got_timeout = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (hold && (out_valid !== 1'b1 || px !== hx || py !== hy)) got_stable = 1'b0;
            if (done === 1'b1) got_done++;
            if (c > 0 && busy === 1'b0) begin
                got_timeout = 1'b0;
                break;
            end
            if (c == restart_at) begin
                cx = 8'd50; cy = 8'd50; radius = 8'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            rdy = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < 32'(pct));
            out_ready = rdy;
            if (out_valid === 1'b1 && rdy && got_n < 64) begin
                got_x[got_n] = px; got_y[got_n] = py; got_n++;
            end
            hold = (out_valid === 1'b1) && !rdy;
            hx = px; hy = py;
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if ({out_valid, px, py, busy, done} !== 19'd0)
            $display("FAIL reset_state: got valid=%0b px=%0d py=%0d busy=%0b done=%0b, want all 0",
                     out_valid, px, py, busy, done);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_r0_latency();
        kick(100, 100, 0);
        chk_cnt++;
        if (busy !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL lat_k: got busy=%0b valid=%0b, want busy=1 valid=0", busy, out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL lat_k1: got valid=%0b, want 0", out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (out_valid !== 1'b1) $display("FAIL lat_k2: got valid=%0b, want 1", out_valid);
        else pass_cnt++;
        collect(100, -1);
        chk_cnt++;
        if (got_timeout || got_n != 1 || got_x[0] !== 8'd100 || got_y[0] !== 8'd100)
            $display("FAIL r0_points: got n=%0d first=(%0d,%0d) to=%0b, want n=1 (100,100)",
                     got_n, got_x[0], got_y[0], got_timeout);
        else pass_cnt++;
        chk_cnt++;
        if (got_done != 1) $display("FAIL r0_done: got %0d pulses, want 1", got_done);
        else pass_cnt++;
    endtask

    task automatic test_r2(input int pct, input int restart_at, input string tag);
        kick(100, 100, 2);
        collect(pct, restart_at);
        chk_cnt++;
        if (got_timeout || got_n != 12)
            $display("FAIL %s_count: got n=%0d to=%0b, want 12", tag, got_n, got_timeout);
        else pass_cnt++;
        for (int i = 0; i < 12 && i < got_n; i++) begin
            chk_cnt++;
            if (got_x[i] !== 8'(exp2_x[i]) || got_y[i] !== 8'(exp2_y[i]))
                $display("FAIL %s_pt%0d: got (%0d,%0d), want (%0d,%0d)",
                         tag, i, got_x[i], got_y[i], exp2_x[i], exp2_y[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (got_done != 1) $display("FAIL %s_done: got %0d pulses, want 1", tag, got_done);
        else pass_cnt++;
        chk_cnt++;
        if (!got_stable) $display("FAIL %s_stable: got px/py changed under stall, want stable", tag);
        else pass_cnt++;
        repeat (4) @(posedge clk);
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL %s_idle_after: got busy=%0b valid=%0b, want 0 0", tag, busy, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_clip();
        kick(0, 0, 1);
        collect(100, -1);
        chk_cnt++;
        if (got_timeout || got_n != 2)
            $display("FAIL clip_count: got n=%0d to=%0b, want 2", got_n, got_timeout);
        else pass_cnt++;
        chk_cnt++;
        if (got_x[0] !== 8'd1 || got_y[0] !== 8'd0 || got_x[1] !== 8'd0 || got_y[1] !== 8'd1)
            $display("FAIL clip_points: got (%0d,%0d),(%0d,%0d), want (1,0),(0,1)",
                     got_x[0], got_y[0], got_x[1], got_y[1]);
        else pass_cnt++;
        chk_cnt++;
        if (got_done != 1) $display("FAIL clip_done: got %0d pulses, want 1", got_done);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int  acc = 0;
        bit  saw_done = 1'b0;
        kick(100, 100, 5);
        out_ready = 1'b1;
        for (int c = 0; c < 100 && acc < 3; c++) begin
            if (out_valid === 1'b1) acc++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_cnt++;
        if (acc != 3 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_state: got acc=%0d valid=%0b busy=%0b done=%0b, want 3 0 0 0",
                     acc, out_valid, busy, done);
        else pass_cnt++;
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1 || out_valid === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk_cnt++;
        if (saw_done) $display("FAIL midrst_quiet: got done/valid after reset, want none");
        else pass_cnt++;
        kick(100, 100, 1);
        collect(100, -1);
        chk_cnt++;
        if (got_timeout || got_n != 4 || got_done != 1 ||
            got_x[0] !== 8'd101 || got_y[0] !== 8'd100 || got_x[1] !== 8'd100 || got_y[1] !== 8'd101 ||
            got_x[2] !== 8'd99  || got_y[2] !== 8'd100 || got_x[3] !== 8'd100 || got_y[3] !== 8'd99)
            $display("FAIL midrst_restart: got n=%0d done=%0d p0=(%0d,%0d) p3=(%0d,%0d), want 4 1 (101,100) (100,99)",
                     got_n, got_done, got_x[0], got_y[0], got_x[3], got_y[3]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_r0_latency();
        test_r2(100, -1, "r2");
        test_clip();
        test_r2(30, -1, "bp");
        test_r2(100, 4, "busy_ign");
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
